// File: rtl/gb_pkg.sv
// Shared constants, state encoding and scoring table for the game-board line-clear logic.
package gb_pkg;

  localparam logic [5:0]  OP_REMOVE_LINE = 6'b011101;
  localparam int unsigned NUM_ROWS       = 20;
  localparam int unsigned NUM_COLS       = 10;
  localparam int unsigned IDX_W          = 5;

  localparam logic [10:0] PTS_1 = 11'd40;
  localparam logic [10:0] PTS_2 = 11'd100;
  localparam logic [10:0] PTS_3 = 11'd300;
  localparam logic [10:0] PTS_4 = 11'd1200;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StIssue,
    StDone
  } state_e;

  function automatic logic [10:0] line_points(input logic [2:0] n);
    logic [10:0] pts;
    case (n)
      3'd0:    pts = 11'd0;
      3'd1:    pts = PTS_1;
      3'd2:    pts = PTS_2;
      3'd3:    pts = PTS_3;
      default: pts = PTS_4;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/gb_lowest_line.sv
// Priority encoder: index of the lowest full row plus an any-row-full flag.
module gb_lowest_line #(
  parameter int unsigned NUM_ROWS = 20,
  parameter int unsigned IDX_W    = 5
) (
  input  logic [NUM_ROWS-1:0] line_status,
  output logic [IDX_W-1:0]    idx,
  output logic                valid
);

  always_comb begin
    idx   = '0;
    valid = |line_status;
    // Walk downward so the lowest set bit is the last one written.
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (line_status[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/gb_line_clear_ctrl.sv
// Line-clear sequencer: removes full rows one at a time after a piece locks, owns the
// board instruction port while busy, and keeps the saturating score.
module gb_line_clear_ctrl #(
  parameter int unsigned NUM_ROWS   = 20,
  parameter int unsigned MAX_CLEARS = 4,
  parameter int unsigned SCORE_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                score_clr,
  input  logic [NUM_ROWS-1:0] line_status,
  input  logic [31:0]         cpu_instr,
  output logic [31:0]         instr_out,
  output logic                cpu_stall,
  output logic                busy,
  output logic                done,
  output logic [2:0]          lines_cleared,
  output logic                overflow,
  output logic [SCORE_W-1:0]  score
);
  import gb_pkg::*;

  localparam logic [2:0] MaxCnt = 3'(MAX_CLEARS);

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [2:0]           lines_q, lines_d;
  logic                 ovf_q, ovf_d;
  logic                 score_add;
  logic [IDX_W-1:0]     low_idx;
  logic                 low_valid;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_sat;

  gb_lowest_line #(
    .NUM_ROWS (NUM_ROWS),
    .IDX_W    (IDX_W)
  ) u_lowest_line (
    .line_status (line_status),
    .idx         (low_idx),
    .valid       (low_valid)
  );

  assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(line_points(cnt_q));
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  // Results are committed on the SCAN->DONE edge so they are already valid while done is high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    lines_d   = lines_q;
    ovf_d     = ovf_q;
    score_add = 1'b0;
    instr_out = '0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        instr_out = cpu_instr;
        if (start) begin
          cnt_d   = '0;
          lines_d = '0;
          ovf_d   = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (!low_valid) begin
          lines_d   = cnt_q;
          score_add = 1'b1;
          state_d   = StDone;
        end else if (cnt_q == MaxCnt) begin
          lines_d   = cnt_q;
          ovf_d     = 1'b1;
          score_add = 1'b1;
          state_d   = StDone;
        end else begin
          idx_d   = low_idx;
          state_d = StIssue;
        end
      end
      StIssue: begin
        instr_out = {OP_REMOVE_LINE, 21'b0, idx_q};
        cnt_d     = cnt_q + 3'd1;
        state_d   = StScan;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (score_clr)      score_d = '0;
    else if (score_add) score_d = score_sat;
    else                score_d = score_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      score_q <= '0;
      lines_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      score_q <= score_d;
      lines_q <= lines_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cpu_stall     = (state_q != StIdle);
  assign busy          = cpu_stall;
  assign lines_cleared = lines_q;
  assign overflow      = ovf_q;
  assign score         = score_q;

endmodule

// File: tb/tb_gb_line_clear_ctrl.sv
// Scoreboard bench for gb_line_clear_ctrl: stimulus pushes expectations, a monitor pops them.
module tb_gb_line_clear_ctrl;

  localparam logic [5:0] OP = 6'b011101;

  logic        clk = 1'b0;
  logic        rst, start, score_clr;
  logic [19:0] line_status;
  logic [31:0] cpu_instr, instr_out;
  logic        cpu_stall, busy, done, overflow;
  logic [2:0]  lines_cleared;
  logic [15:0] score;

  gb_line_clear_ctrl #(
    .NUM_ROWS   (20),
    .MAX_CLEARS (4),
    .SCORE_W    (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .score_clr     (score_clr),
    .line_status   (line_status),
    .cpu_instr     (cpu_instr),
    .instr_out     (instr_out),
    .cpu_stall     (cpu_stall),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .overflow      (overflow),
    .score         (score)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  lines;
    logic        ovf;
    logic [15:0] score;
    int          cyc;
  } seq_exp_t;

  typedef struct {
    logic [31:0] word;
    int          cyc;
  } iss_exp_t;

  seq_exp_t seq_q[$];
  iss_exp_t iss_q[$];
  int       model_score = 0;
  int       checks = 0;
  int       failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int points(input int k);
    case (k)
      0:       return 0;
      1:       return 40;
      2:       return 100;
      3:       return 300;
      default: return 1200;
    endcase
  endfunction

  // Board behaviour: drop row idx, rows above slide down one, an empty row enters on top.
  function automatic logic [19:0] remove_row(input logic [19:0] v, input int idx);
    logic [19:0] low_mask;
    low_mask = (20'd1 << idx) - 20'd1;
    return (v & low_mask) | ((v >> (idx + 1)) << idx);
  endfunction

  // Expected outcome from the set of full rows: the k-th removal (lowest first) of a row
  // originally at r lands at r-k because k rows beneath it are already gone.
  task automatic push_expect(input logic [19:0] rows, input bit stuck);
    int       full[$];
    int       k;
    bit       ovf;
    iss_exp_t ie;
    seq_exp_t se;
    for (int i = 0; i < 20; i++) if (rows[i]) full.push_back(i);
    if (stuck) begin
      k   = 4;
      ovf = 1'b1;
      for (int j = 0; j < 4; j++) begin
        ie.word = {OP, 21'b0, 5'd5};
        ie.cyc  = cyc + 2 * j + 2;
        iss_q.push_back(ie);
      end
    end else begin
      k   = (full.size() < 4) ? full.size() : 4;
      ovf = (full.size() > 4);
      for (int j = 0; j < k; j++) begin
        ie.word = {OP, 21'b0, 5'(full[j] - j)};
        ie.cyc  = cyc + 2 * j + 2;
        iss_q.push_back(ie);
      end
    end
    model_score = model_score + points(k);
    if (model_score > 65535) model_score = 65535;
    se.lines = 3'(k);
    se.ovf   = ovf;
    se.score = 16'(model_score);
    se.cyc   = cyc + 2 * k + 2;
    seq_q.push_back(se);
  endtask

  task automatic run_seq(input logic [19:0] rows, input bit stuck, input bit disturb);
    bit finished = 1'b0;
    @(negedge clk);
    line_status = rows;
    cpu_instr   = {6'b011010, 26'($urandom)};
    push_expect(rows, stuck);
    start = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      if (disturb && t == 2) begin
        start     = 1'b1;
        cpu_instr = 32'h6800_0000;
      end
      if (instr_out[31:26] == OP) begin
        line_status = remove_row(line_status, int'(instr_out[4:0]));
        if (stuck) line_status[5] = 1'b1;
      end
    end
    if (!finished) begin
      failures++;
      $display("FAIL seq_timeout: busy still 1 want 0 after 40 cycles");
    end
  endtask

  task automatic reset_mid();
    bit hit = 1'b0;
    @(negedge clk);
    line_status = 20'h0_0111;
    push_expect(line_status, 1'b0);
    start = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && instr_out[31:26] == OP) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reset_mid_reached_issue", hit, 1);
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_done", done, 0);
    chk("rst_lines", lines_cleared, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_score", score, 0);
    chk("rst_instr", instr_out, cpu_instr);
    seq_q.delete();
    iss_q.delete();
    model_score = 0;
    @(negedge clk);
    rst         = 1'b0;
    line_status = '0;
  endtask

  // Monitor: pops expectations when the DUT presents an issue or a done pulse.
  initial begin
    iss_exp_t ie;
    seq_exp_t se;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        if (busy) begin
          chk("stall_matches_busy", cpu_stall, 1);
          chk("cpu_blocked_while_busy", instr_out == cpu_instr, 0);
          if (instr_out[31:26] == OP) begin
            if (iss_q.size() == 0) begin
              chk("unexpected_issue", instr_out, 0);
            end else begin
              ie = iss_q.pop_front();
              chk("issue_word", instr_out, ie.word);
              chk("issue_cycle", cyc, ie.cyc);
            end
          end
        end else begin
          chk("idle_passthru", instr_out, cpu_instr);
        end
        if (done) begin
          if (seq_q.size() == 0) begin
            chk("unexpected_done", done, 0);
          end else begin
            se = seq_q.pop_front();
            chk("lines_cleared", lines_cleared, se.lines);
            chk("overflow", overflow, se.ovf);
            chk("score", score, se.score);
            chk("done_cycle", cyc, se.cyc);
            chk("done_while_busy", busy, 1);
            chk("issues_outstanding", iss_q.size(), 0);
          end
        end
      end
    end
  end

  initial begin
    logic [19:0] rows;
    int          nsel;
    rst         = 1'b1;
    start       = 1'b0;
    score_clr   = 1'b0;
    line_status = '0;
    cpu_instr   = 32'h6800_0123;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_stall", cpu_stall, 0);
    chk("reset_done", done, 0);
    chk("reset_lines", lines_cleared, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_score", score, 0);
    chk("reset_instr", instr_out, 32'h6800_0123);
    rst = 1'b0;

    run_seq(20'h0, 1'b0, 1'b0);
    run_seq(20'h8, 1'b0, 1'b0);
    run_seq(20'hF, 1'b0, 1'b0);
    run_seq(20'h20, 1'b1, 1'b0);
    run_seq(20'h8_0402, 1'b0, 1'b1);
    run_seq(20'hF_C03F, 1'b0, 1'b1);

    for (int n = 0; n < 60; n++) begin
      nsel = $urandom_range(0, 6);
      rows = '0;
      while ($countones(rows) < nsel) rows[$urandom_range(0, 19)] = 1'b1;
      run_seq(rows, 1'b0, (rows != 0) && ($urandom_range(0, 1) == 1));
    end

    @(negedge clk);
    score_clr = 1'b1;
    @(negedge clk);
    score_clr   = 1'b0;
    model_score = 0;
    chk("score_clr", score, 0);

    for (int n = 0; n < 56; n++) run_seq(20'hF, 1'b0, 1'b0);
    chk("score_saturated", score, 16'hFFFF);
    run_seq(20'h3, 1'b0, 1'b0);
    chk("score_stays_saturated", score, 16'hFFFF);

    reset_mid();
    run_seq(20'h3, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("seq_queue_drained", seq_q.size(), 0);
    chk("issue_queue_drained", iss_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
